sine_nco: RTL and testbench

SINE_NCO -- requirements
Module: sine_nco

---
 rtl/sine_nco_pkg.sv | 25 ++
 rtl/sine_nco_qlut.sv | 22 ++
 rtl/sine_nco.sv | 126 ++++++++++++
 tb/tb_sine_nco.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sine_nco_pkg.sv
// Shared types, default parameter values and quarter-wave table generator for sine_nco.
package sine_nco_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_PHASE_W = 16;
    localparam int DEF_LUT_AW  = 6;
    localparam int DEF_FTW_RST = 'h0400;

    // Samples sit at bucket midpoints, so entry 0 is never zero and the last entry never exceeds full scale.
    function automatic int qtab_entry(input int k, input int data_w, input int lut_aw);
        real amp;
        real arg;
        amp = (2.0 ** (data_w - 1)) - 1.0;
        arg = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / (2.0 ** lut_aw);
        return $rtoi(amp * $sin(arg) + 0.5);
    endfunction

endpackage

// File: rtl/sine_nco_qlut.sv
// Combinational quarter-wave sine ROM; contents fixed at elaboration from sine_nco_pkg::qtab_entry.
module sine_nco_qlut
    import sine_nco_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LUT_AW = DEF_LUT_AW
) (
    input  logic        [LUT_AW-1:0] addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int DEPTH = 2 ** LUT_AW;

    logic signed [DATA_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = DATA_W'(qtab_entry(k, DATA_W, LUT_AW));
    end

    assign data = rom[addr];

endmodule

// File: rtl/sine_nco.sv
// Phase-accumulator sine NCO with quarter-wave ROM and a two-stage ready/valid pipeline.
// Optional quadrature output cos_data when SINE_NCO_QUAD_EN is defined.
module sine_nco
    import sine_nco_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 PHASE_W = DEF_PHASE_W,
    parameter int                 LUT_AW  = DEF_LUT_AW,
    parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(DEF_FTW_RST)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic        [PHASE_W-1:0] ftw,
    input  logic                      ftw_load,
    input  logic                      phase_clr,
    output logic signed [DATA_W-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SINE_NCO_QUAD_EN
    ,
    output logic signed [DATA_W-1:0]  cos_data
`endif
);

    localparam int TOP_W = LUT_AW + 2;
    localparam logic [TOP_W-1:0] QUARTER = {2'b01, {LUT_AW{1'b0}}};

    if (PHASE_W < TOP_W) begin : g_bad_cfg
        $error("sine_nco: PHASE_W must be at least LUT_AW+2");
    end

    // Returns {negate, rom_addr}; odd quadrants walk the table backwards (~idx == 2^LUT_AW-1-idx).
    function automatic logic [LUT_AW:0] decode(input logic [TOP_W-1:0] ph);
        quad_e             q;
        logic [LUT_AW-1:0] idx;
        q   = quad_e'(ph[TOP_W-1 -: 2]);
        idx = ph[LUT_AW-1:0];
        if (q == Q1 || q == Q3) idx = ~idx;
        return {(q == Q2 || q == Q3), idx};
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(
        input logic signed [DATA_W-1:0] v,
        input logic                     neg
    );
        return neg ? -v : v;
    endfunction

    logic        [PHASE_W-1:0] acc;
    logic        [PHASE_W-1:0] ftw_reg;
    logic        [TOP_W-1:0]   phase_p1;
    logic                      vld_p1;
    logic                      vld_p2;
    logic signed [DATA_W-1:0]  sin_p2;
    logic                      stall;
    logic                      advance;
    logic        [LUT_AW:0]    sin_dec;
    logic signed [DATA_W-1:0]  sin_mag;

    assign stall   = vld_p2 && !out_ready;
    assign advance = en && !stall && !phase_clr;

    // Stage 0 -> 1: accumulator and phase capture
    always_ff @(posedge clk) begin
        if (advance) phase_p1 <= acc[PHASE_W-1 -: TOP_W];
    end

    assign sin_dec = decode(phase_p1);

    sine_nco_qlut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_sin_lut (
        .addr (sin_dec[LUT_AW-1:0]),
        .data (sin_mag)
    );

    // Stage 1 -> 2: sign-corrected table value into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ftw_reg <= FTW_RST;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            sin_p2  <= '0;
        end else begin
            if (ftw_load) ftw_reg <= ftw;
            if (phase_clr) begin
                acc    <= '0;
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else if (!stall) begin
                vld_p1 <= en;
                vld_p2 <= vld_p1;
                if (en) acc <= acc + ftw_reg;
            end
            if (!stall) sin_p2 <= apply_sign(sin_mag, sin_dec[LUT_AW]);
        end
    end

    assign out_data  = sin_p2;
    assign out_valid = vld_p2;

`ifdef SINE_NCO_QUAD_EN
    logic        [LUT_AW:0]   cos_dec;
    logic signed [DATA_W-1:0] cos_mag;
    logic signed [DATA_W-1:0] cos_p2;

    // A quarter-turn offset only touches the quadrant bits, so the truncated phase suffices.
    assign cos_dec = decode(phase_p1 + QUARTER);

    sine_nco_qlut #(.DATA_W(DATA_W), .LUT_AW(LUT_AW)) u_cos_lut (
        .addr (cos_dec[LUT_AW-1:0]),
        .data (cos_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_p2 <= '0;
        end else if (!stall) begin
            cos_p2 <= apply_sign(cos_mag, cos_dec[LUT_AW]);
        end
    end

    assign cos_data = cos_p2;
`endif

endmodule

// File: tb/tb_sine_nco.sv
// Self-checking bench for sine_nco: vector table, directed corner sequences and randomized scoreboard run.
module tb_sine_nco;

    localparam int  DW = 8;
    localparam int  PW = 16;
    localparam int  AW = 6;
    localparam real PI = 3.14159265358979;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b1;
    logic                 en        = 1'b0;
    logic [PW-1:0]        ftw       = '0;
    logic                 ftw_load  = 1'b0;
    logic                 phase_clr = 1'b0;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
`ifdef SINE_NCO_QUAD_EN
    logic signed [DW-1:0] cos_data;
`endif

    always #5 clk = ~clk;

    sine_nco #(
        .DATA_W  (DW),
        .PHASE_W (PW),
        .LUT_AW  (AW),
        .FTW_RST (16'h0400)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ftw       (ftw),
        .ftw_load  (ftw_load),
        .phase_clr (phase_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SINE_NCO_QUAD_EN
        ,
        .cos_data  (cos_data)
`endif
    );

    int            errors = 0;
    int            checks = 0;
    int            k;
    logic [PW-1:0] ftw_cur;

    // Ideal sine evaluated at the midpoint of the phase bucket, rounded half away from zero.
    function automatic int ref_sample(input logic [PW-1:0] ph);
        real ang;
        real x;
        int  b;
        b   = int'(ph >> (PW - AW - 2));
        ang = 2.0 * PI * (real'(b) + 0.5) / real'(2 ** (AW + 2));
        x   = real'((2 ** (DW - 1)) - 1) * $sin(ang);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: scoreboard the visible sample, drive inputs, advance one full cycle.
    task automatic step(input logic e, input logic r, input logic c, input logic l, input logic [PW-1:0] f);
        if (out_valid) begin
            check("sb_sin", int'(out_data), ref_sample(PW'(k * int'(ftw_cur))));
`ifdef SINE_NCO_QUAD_EN
            check("sb_cos", int'(cos_data), ref_sample(PW'(k * int'(ftw_cur)) + PW'(1 << (PW - 2))));
`endif
        end
        en        = e;
        out_ready = r;
        phase_clr = c;
        ftw_load  = l;
        ftw       = f;
        if (out_valid && r) k++;
        @(posedge clk);
        if (c) k = 0;
        if (l) ftw_cur = f;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        ftw_load  = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        k       = 0;
        ftw_cur = 16'h0400;
    endtask

    typedef struct {
        logic [PW-1:0] ftw;
        int            cyc;
        logic          vld;
        int            data;
    } vec_t;

    vec_t          tbl [13];
    logic [PW-1:0] cur_f;
    int            cyc;
    logic [PW-1:0] ftw_r;

    initial begin
        k       = 0;
        ftw_cur = 16'h0400;
        cur_f   = '0;
        cyc     = 0;

        tbl[0]  = '{16'h4000, 1, 1'b0, 0};
        tbl[1]  = '{16'h4000, 2, 1'b1, 2};
        tbl[2]  = '{16'h4000, 3, 1'b1, 127};
        tbl[3]  = '{16'h4000, 4, 1'b1, -2};
        tbl[4]  = '{16'h4000, 5, 1'b1, -127};
        tbl[5]  = '{16'h4000, 6, 1'b1, 2};
        tbl[6]  = '{16'h0400, 2, 1'b1, 2};
        tbl[7]  = '{16'h0400, 10, 1'b1, 91};
        tbl[8]  = '{16'h0400, 18, 1'b1, 127};
        tbl[9]  = '{16'h0400, 34, 1'b1, -2};
        tbl[10] = '{16'h0400, 42, 1'b1, -91};
        tbl[11] = '{16'h0400, 50, 1'b1, -127};
        tbl[12] = '{16'h0400, 66, 1'b1, 2};

        #1;
        for (int i = 0; i < 13; i++) begin
            if (i == 0 || tbl[i].ftw != cur_f || tbl[i].cyc <= cyc) begin
                do_reset();
                step(1'b0, 1'b1, 1'b0, 1'b1, tbl[i].ftw);
                cur_f = tbl[i].ftw;
                cyc   = 0;
            end
            while (cyc < tbl[i].cyc) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
                cyc++;
            end
            check($sformatf("vec%0d_vld", i), int'(out_valid), int'(tbl[i].vld));
            if (tbl[i].vld) check($sformatf("vec%0d_data", i), int'(out_data), tbl[i].data);
        end

        // Backpressure: five stalled cycles mid-stream, then resume.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            check("stall_vld", int'(out_valid), 1);
            step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        // Phase clear combined with a tuning-word load.
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h4000);
        check("clr_vld", int'(out_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("clr_vld_p1", int'(out_valid), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("clr_first_vld", int'(out_valid), 1);
        check("clr_first_data", int'(out_data), 2);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        // Asynchronous reset mid-stream, then restart on the reset tuning word.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("rst_restart_vld", int'(out_valid), 1);
        check("rst_restart_data", int'(out_data), 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

        // Randomized enable and backpressure against the scoreboard.
        for (int t = 0; t < 4; t++) begin
            ftw_r = 16'($urandom_range(32'h7FFF, 32'h0100));
            step(1'b0, 1'b1, 1'b1, 1'b1, ftw_r);
            for (int i = 0; i < 200; i++)
                step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, 1'b0, 1'b0, 16'h0);
            for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            check("drain_vld", int'(out_valid), 0);
            check("rand_progress", int'(k > 20), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
